// File: rtl/vscpu_mem_responder.sv
// Word-addressed 32-bit RAM for the VSCPU plus a big-endian byte-stream program loader.
// Latency: CPU read data appears on data_fromRAM one clock after the address (write-first).
// Backpressure: load_ready is low outside LOAD (commit/flush cycles); the CPU is held in reset while loading.
module vscpu_mem_responder #(
    parameter int ADDR_LEN  = 14,
    parameter int MEM_DEPTH = 16384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrEn,
    input  logic [ADDR_LEN-1:0] addr_toRAM,
    input  logic [31:0]         data_toRAM,
    output logic [31:0]         data_fromRAM,
    input  logic                load_en,
    input  logic                load_valid,
    input  logic [7:0]          load_byte,
    output logic                load_ready,
    output logic                cpu_hold,
    output logic [ADDR_LEN:0]   load_words,
    output logic                load_overflow
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = ADDR_LEN + 1;
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(MEM_DEPTH);
    localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [MEM_DEPTH];

    logic [31:0]         data_q, data_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         shift_q, shift_d;
    logic [ADDR_LEN-1:0] load_addr_q, load_addr_d;
    logic [CNT_W-1:0]    load_words_q, load_words_d;
    logic                ovf_q, ovf_d;

    logic             hs;
    logic [2:0]       cnt_inc;
    logic             cpu_in_range;
    logic             load_in_range;
    logic [IDX_W-1:0] cpu_idx;
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdat;
    logic [31:0]      flush_word;

    assign cpu_in_range  = ({1'b0, addr_toRAM} < DEPTH_C);
    assign load_in_range = ({1'b0, load_addr_q} < DEPTH_C);
    assign cpu_idx       = IDX_W'(addr_toRAM);
    assign hs            = load_valid && load_ready;
    assign cnt_inc       = byte_cnt_q + {2'b00, hs};

    assign data_fromRAM  = data_q;
    assign load_words    = load_words_q;
    assign load_overflow = ovf_q;

    // FSM state register; reset aborts any session immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a 4th byte always commits, a dropped load_en flushes any partial word
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_en) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (hs && byte_cnt_q == 3'd3) begin
                    state_d = S_COMMIT;
                end else if (!load_en) begin
                    state_d = (cnt_inc == 3'd0) ? S_IDLE : S_FLUSH;
                end
            end
            S_COMMIT: state_d = load_en ? S_LOAD : S_IDLE;
            S_FLUSH:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: decoded straight from the state register
    always_comb begin
        cpu_hold   = (state_q != S_IDLE);
        load_ready = (state_q == S_LOAD);
    end

    // Partial word left-justified so missing low bytes read as zero
    always_comb begin
        flush_word = shift_q;
        case (byte_cnt_q)
            3'd1:    flush_word = {shift_q[7:0],  24'h0};
            3'd2:    flush_word = {shift_q[15:0], 16'h0};
            3'd3:    flush_word = {shift_q[23:0], 8'h0};
            default: flush_word = shift_q;
        endcase
    end

    // Datapath next state: CPU port owns the RAM in IDLE, loader owns it otherwise
    always_comb begin
        data_d       = '0;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        load_addr_d  = load_addr_q;
        load_words_d = load_words_q;
        ovf_d        = ovf_q;
        mem_we       = 1'b0;
        mem_widx     = cpu_idx;
        mem_wdat     = data_toRAM;
        case (state_q)
            S_IDLE: begin
                if (wrEn && cpu_in_range) begin
                    mem_we = 1'b1;
                    data_d = data_toRAM;
                end else if (cpu_in_range) begin
                    data_d = mem[cpu_idx];
                end
                if (load_en) begin
                    byte_cnt_d   = '0;
                    shift_d      = '0;
                    load_addr_d  = '0;
                    load_words_d = '0;
                    ovf_d        = 1'b0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    shift_d    = {shift_q[23:0], load_byte};
                    byte_cnt_d = cnt_inc;
                end
            end
            S_COMMIT, S_FLUSH: begin
                mem_we     = load_in_range;
                mem_widx   = IDX_W'(load_addr_q);
                mem_wdat   = (state_q == S_COMMIT) ? shift_q : flush_word;
                byte_cnt_d = '0;
                if (load_words_q != CNT_MAX) begin
                    load_words_d = load_words_q + CNT_W'(1);
                end
                if (load_addr_q == LAST_ADDR) begin
                    load_addr_d = '0;
                    ovf_d       = 1'b1;
                end else begin
                    load_addr_d = load_addr_q + ADDR_LEN'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            load_addr_q  <= '0;
            load_words_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            data_q       <= data_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            load_addr_q  <= load_addr_d;
            load_words_q <= load_words_d;
            ovf_q        <= ovf_d;
        end
    end

    // RAM array: contents survive reset, single shared write port
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// Randomized bench for vscpu_mem_responder: CPU accesses and loader sessions against a word-array model.
// Expected read data is queued at issue time and compared by an independent monitor.
// Loader status (counts, overflow, hold, ready) is checked directly at session boundaries.
module tb_vscpu_mem_responder;

    localparam int AL     = 6;
    localparam int DEPTH  = 16;
    localparam int LW_MAX = 127;

    logic            clk = 1'b0;
    logic            rst;
    logic            wrEn;
    logic [AL-1:0]   addr_toRAM;
    logic [31:0]     data_toRAM;
    logic [31:0]     data_fromRAM;
    logic            load_en;
    logic            load_valid;
    logic [7:0]      load_byte;
    logic            load_ready;
    logic            cpu_hold;
    logic [AL:0]     load_words;
    logic            load_overflow;

    always #5 clk = ~clk;

    vscpu_mem_responder #(.ADDR_LEN(AL), .MEM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wrEn          (wrEn),
        .addr_toRAM    (addr_toRAM),
        .data_toRAM    (data_toRAM),
        .data_fromRAM  (data_fromRAM),
        .load_en       (load_en),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_ready    (load_ready),
        .cpu_hold      (cpu_hold),
        .load_words    (load_words),
        .load_overflow (load_overflow)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic        mon_vld = 1'b0;
    logic [7:0]  src_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: any cycle flagged at the edge as a CPU access is checked one cycle later
    initial begin : monitor
        logic p;
        forever begin
            @(posedge clk);
            p = mon_vld;
            @(negedge clk);
            if (p) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: read data %h with no expectation queued", data_fromRAM);
                end else begin
                    chk("rd_data", data_fromRAM, exp_q.pop_front());
                end
            end
        end
    end

    // One CPU access; caller is #1 after a rising edge
    task automatic cpu_op(input logic we, input logic [AL-1:0] a, input logic [31:0] d);
        logic [31:0] e;
        wrEn       = we;
        addr_toRAM = a;
        data_toRAM = d;
        mon_vld    = 1'b1;
        if (int'(a) < DEPTH) begin
            if (we) model_mem[a[3:0]] = d;
            e = model_mem[a[3:0]];
        end else begin
            e = 32'h0;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        wrEn    = 1'b0;
        mon_vld = 1'b0;
    endtask

    task automatic dump_mem();
        for (int k = 0; k < DEPTH; k++) cpu_op(1'b0, AL'(k), 32'h0);
    endtask

    // Feed src_q through the loader.
    // mode 0: drop load_en after the last byte; 1: drop it with the last handshake; 2: leave session open
    task automatic load_session(input int mode);
        int   n      = src_q.size();
        int   i      = 0;
        int   budget = 0;
        int   words;
        int   k;
        logic hs;
        logic commit_next = 1'b0;
        logic hold_ok     = 1'b1;
        logic [31:0] w;
        load_en = 1'b1;
        @(posedge clk); #1;
        while (i < n && budget < 5000) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_byte  = src_q[i];
            @(negedge clk);
            if (commit_next) begin
                chk("commit_ready_low", {31'h0, load_ready}, 32'h0);
                commit_next = 1'b0;
            end
            if (!cpu_hold) hold_ok = 1'b0;
            hs = load_valid && load_ready;
            if (hs && mode == 1 && i == n - 1) load_en = 1'b0;
            @(posedge clk); #1;
            if (hs) begin
                i++;
                if (i % 4 == 0) commit_next = 1'b1;
            end
            budget++;
        end
        load_valid = 1'b0;
        if (i < n) begin
            total++;
            bad++;
            $display("FAIL load_timeout: accepted %0d of %0d bytes", i, n);
        end
        if (mode == 2) return;
        load_en = 1'b0;
        if (commit_next) begin
            @(negedge clk);
            chk("commit_ready_low", {31'h0, load_ready}, 32'h0);
            if (!cpu_hold) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        k = 0;
        while (cpu_hold && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("hold_during_load", {31'h0, hold_ok}, 32'h1);
        chk("hold_released", {31'h0, cpu_hold}, 32'h0);
        chk("ready_idle", {31'h0, load_ready}, 32'h0);
        words = (n + 3) / 4;
        for (int q = 0; q < words; q++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                w = w << 8;
                if (4 * q + j < n) w = w | {24'h0, src_q[4 * q + j]};
            end
            model_mem[q % DEPTH] = w;
        end
        chk("load_words", {25'h0, load_words}, (words > LW_MAX) ? LW_MAX : words);
        chk("load_overflow", {31'h0, load_overflow}, (words > DEPTH) ? 32'h1 : 32'h0);
    endtask

    initial begin : stim
        int n;
        rst        = 1'b1;
        wrEn       = 1'b0;
        addr_toRAM = '0;
        data_toRAM = '0;
        load_en    = 1'b0;
        load_valid = 1'b0;
        load_byte  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data_fromRAM, 32'h0);
        chk("rst_ready", {31'h0, load_ready}, 32'h0);
        chk("rst_hold", {31'h0, cpu_hold}, 32'h0);
        chk("rst_words", {25'h0, load_words}, 32'h0);
        chk("rst_ovf", {31'h0, load_overflow}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < DEPTH; k++) cpu_op(1'b1, AL'(k), $urandom());

        cpu_op(1'b1, 6'd5, 32'h1234_5678);
        cpu_op(1'b0, 6'd5, 32'h0);
        cpu_op(1'b1, 6'd3, 32'hA);
        cpu_op(1'b1, 6'd4, 32'hB);
        cpu_op(1'b0, 6'd3, 32'h0);
        cpu_op(1'b0, 6'd4, 32'h0);
        cpu_op(1'b0, 6'd20, 32'h0);
        cpu_op(1'b1, 6'd20, $urandom());
        dump_mem();

        for (int k = 0; k < 200; k++) begin
            cpu_op(1'($urandom_range(0, 1)), AL'($urandom_range(0, 63)), $urandom());
        end

        src_q = '{8'h10, 8'h00, 8'h40, 8'h01, 8'hD0, 8'h00, 8'h00, 8'h00};
        load_session(0);
        dump_mem();

        src_q = '{8'hAA, 8'hBB};
        load_session(1);
        dump_mem();

        for (int s = 0; s < 4; s++) begin
            src_q.delete();
            n = $urandom_range(1, 30);
            for (int k = 0; k < n; k++) src_q.push_back(8'($urandom()));
            load_session(int'($urandom_range(0, 1)));
            dump_mem();
        end

        src_q.delete();
        for (int k = 0; k < 68; k++) src_q.push_back(8'($urandom()));
        load_session(0);
        dump_mem();

        src_q.delete();
        for (int k = 0; k < 520; k++) src_q.push_back(8'($urandom()));
        load_session(1);
        dump_mem();
        chk("words_hold_idle", {25'h0, load_words}, LW_MAX);

        src_q = '{8'hC0, 8'hFF, 8'hEE, 8'h01, 8'h55, 8'h66};
        model_mem[0] = 32'hC0FF_EE01;
        load_session(2);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_hold", {31'h0, cpu_hold}, 32'h0);
        chk("arst_ready", {31'h0, load_ready}, 32'h0);
        chk("arst_words", {25'h0, load_words}, 32'h0);
        chk("arst_ovf", {31'h0, load_overflow}, 32'h0);
        chk("arst_data", data_fromRAM, 32'h0);
        load_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        dump_mem();

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
